// File: rtl/theia_program_loader.sv
// Byte-stream program/data loader for THEIA compute units: parses host packets from the UART,
// writes unit instruction/data RAMs word by word, toggles per-unit enable bits and answers ACK/NAK.
module theia_program_loader #(
  parameter int NUM_UNITS      = 2,
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  iGlobalClock,
  input  logic                  iGlobalReset,
  input  logic                  iUartByteAvailable,
  input  logic [7:0]            iUartRx,
  output logic                  oUartTxByteAvailable,
  output logic [7:0]            oUartTx,
  output logic [NUM_UNITS-1:0]  oRamWriteEnable,
  output logic                  oRamSelect,
  output logic [ADDR_WIDTH-1:0] oRamAddress,
  output logic [WORD_WIDTH-1:0] oRamData,
  output logic [NUM_UNITS-1:0]  oDeviceEnable,
  output logic                  oBusy
);

  localparam int BPW = WORD_WIDTH / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);
  localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_BAD = 8'hE1;
  localparam logic [7:0] RSP_TMO = 8'hE2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_COUNT,
    S_PAYLOAD
  } state_t;

  state_t                r_state;
  logic [5:0]            r_unit;
  logic                  r_sel;
  logic                  r_bad;
  logic [7:0]            r_addr_hi;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [8:0]            r_words_left;
  logic [BW-1:0]         r_byte_idx;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [TW-1:0]         r_timer;

  logic [WORD_WIDTH-1:0] w_word;
  logic                  w_cmd_bad;
  logic [NUM_UNITS-1:0]  w_cmd_hot;
  logic [NUM_UNITS-1:0]  w_unit_hot;

  always_comb begin
    w_word     = WORD_WIDTH'({r_shift, iUartRx});
    w_cmd_bad  = ({26'd0, iUartRx[5:0]} >= 32'(NUM_UNITS));
    w_cmd_hot  = '0;
    w_unit_hot = '0;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      w_cmd_hot[u]  = (u == {26'd0, iUartRx[5:0]});
      w_unit_hot[u] = (u == {26'd0, r_unit});
    end
  end

  assign oBusy = (r_state != S_IDLE);

  always_ff @(posedge iGlobalClock) begin
    if (iGlobalReset) begin
      r_state              <= S_IDLE;
      r_unit               <= '0;
      r_sel                <= 1'b0;
      r_bad                <= 1'b0;
      r_addr_hi            <= '0;
      r_addr               <= '0;
      r_words_left         <= '0;
      r_byte_idx           <= '0;
      r_shift              <= '0;
      r_timer              <= '0;
      oUartTxByteAvailable <= 1'b0;
      oUartTx              <= '0;
      oRamWriteEnable      <= '0;
      oRamSelect           <= 1'b0;
      oRamAddress          <= '0;
      oRamData             <= '0;
      oDeviceEnable        <= '0;
    end else begin
      oRamWriteEnable      <= '0;
      oUartTxByteAvailable <= 1'b0;

      // A strobe always wins over an expiring timer, so a byte arriving on the last cycle is kept.
      if (r_state != S_IDLE && !iUartByteAvailable) begin
        if (r_timer == TMAX) begin
          r_state              <= S_IDLE;
          r_timer              <= '0;
          oUartTxByteAvailable <= 1'b1;
          oUartTx              <= RSP_TMO;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end

      if (iUartByteAvailable) begin
        r_timer <= '0;
        case (r_state)
          S_IDLE: begin
            r_unit     <= iUartRx[5:0];
            r_sel      <= iUartRx[6];
            r_bad      <= w_cmd_bad;
            r_byte_idx <= '0;
            if (iUartRx[7]) begin
              oUartTxByteAvailable <= 1'b1;
              oUartTx              <= w_cmd_bad ? RSP_BAD : RSP_ACK;
              if (iUartRx[6]) oDeviceEnable <= oDeviceEnable & ~w_cmd_hot;
              else            oDeviceEnable <= oDeviceEnable | w_cmd_hot;
            end else begin
              r_state <= S_ADDR_HI;
            end
          end
          S_ADDR_HI: begin
            r_addr_hi <= iUartRx;
            r_state   <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            r_addr  <= ADDR_WIDTH'({r_addr_hi, iUartRx});
            r_state <= S_COUNT;
          end
          S_COUNT: begin
            r_words_left <= {(iUartRx == 8'd0), iUartRx};
            r_byte_idx   <= '0;
            r_state      <= S_PAYLOAD;
          end
          S_PAYLOAD: begin
            r_shift <= w_word;
            if (r_byte_idx == LAST_BYTE) begin
              r_byte_idx   <= '0;
              r_addr       <= r_addr + 1'b1;
              r_words_left <= r_words_left - 9'd1;
              if (!r_bad) begin
                oRamWriteEnable <= w_unit_hot;
                oRamSelect      <= r_sel;
                oRamAddress     <= r_addr;
                oRamData        <= w_word;
              end
              if (r_words_left == 9'd1) begin
                r_state              <= S_IDLE;
                oUartTxByteAvailable <= 1'b1;
                oUartTx              <= r_bad ? RSP_BAD : RSP_ACK;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_theia_program_loader.sv
// Directed bench for theia_program_loader: packet writes, address wrap, enables, bad unit,
// timeout, line-rate back-to-back packets and reset in the middle of a payload.
module tb_theia_program_loader;

  localparam int TO = 40;

  logic        clk;
  logic        rst;
  logic        avail;
  logic [7:0]  rx;
  logic        tx_av;
  logic [7:0]  tx;
  logic [1:0]  we;
  logic        sel;
  logic [9:0]  addr;
  logic [31:0] data;
  logic [1:0]  den;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [44:0] wq[$];
  logic [7:0]  tq[$];

  theia_program_loader #(
    .NUM_UNITS(2),
    .WORD_WIDTH(32),
    .ADDR_WIDTH(10),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .iGlobalClock(clk),
    .iGlobalReset(rst),
    .iUartByteAvailable(avail),
    .iUartRx(rx),
    .oUartTxByteAvailable(tx_av),
    .oUartTx(tx),
    .oRamWriteEnable(we),
    .oRamSelect(sel),
    .oRamAddress(addr),
    .oRamData(data),
    .oDeviceEnable(den),
    .oBusy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse and response byte, one entry per cycle it is asserted.
  always @(negedge clk) begin
    if (we != 2'b00) wq.push_back({we, sel, addr, data});
    if (tx_av) tq.push_back(tx);
  end

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    avail = 1'b1;
    rx    = b;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      avail = 1'b0;
    end
  endtask

  task automatic put_word(input logic [31:0] w);
    put(w[31:24]); put(w[23:16]); put(w[15:8]); put(w[7:0]);
  endtask

  task automatic test_reset;
    rst = 1'b1; avail = 1'b0; rx = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_av, tx, we, sel, addr, data, den, busy} !== 57'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {tx_av, tx, we, sel, addr, data, den, busy});
    end
    rst = 1'b0;
    quiet(2);
    checks++;
    if (busy !== 1'b0 || wq.size() != 0 || tq.size() != 0) begin
      errors++;
      $display("FAIL reset_idle busy=%b writes=%0d resp=%0d want 0 0 0", busy, wq.size(), tq.size());
    end
  endtask

  task automatic test_write_instr;
    logic [44:0] exp_w[2];
    exp_w[0] = {2'b01, 1'b0, 10'h001, 32'h11223344};
    exp_w[1] = {2'b01, 1'b0, 10'h002, 32'hDEADBEEF};
    wq.delete(); tq.delete();
    put(8'h00);
    quiet(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wi_busy got %b want 1", busy);
    end
    put(8'h00); put(8'h01); put(8'h02);
    put_word(32'h11223344);
    put_word(32'hDEADBEEF);
    quiet(4);
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL wi_count got %0d want 2", wq.size());
    end
    for (int i = 0; i < 2 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL wi_write%0d got %h want %h", i, wq[i], exp_w[i]);
      end
    end
    checks++;
    if (tq.size() != 1 || tq[0] !== 8'hA5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wi_resp got n=%0d first=%h busy=%b want 1 a5 0", tq.size(), (tq.size() > 0) ? tq[0] : 8'hxx, busy);
    end
  endtask

  task automatic test_write_data_wrap;
    logic [44:0] exp_w[2];
    exp_w[0] = {2'b10, 1'b1, 10'h3FF, 32'h01020304};
    exp_w[1] = {2'b10, 1'b1, 10'h000, 32'hA0B0C0D0};
    wq.delete(); tq.delete();
    put(8'h41); put(8'h03); put(8'hFF); put(8'h02);
    put_word(32'h01020304);
    put_word(32'hA0B0C0D0);
    quiet(4);
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL wd_count got %0d want 2", wq.size());
    end
    for (int i = 0; i < 2 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL wd_write%0d got %h want %h", i, wq[i], exp_w[i]);
      end
    end
    checks++;
    if (tq.size() != 1 || tq[0] !== 8'hA5) begin
      errors++;
      $display("FAIL wd_resp got n=%0d want one a5", tq.size());
    end
  endtask

  task automatic test_enable;
    logic [7:0] cmds[4];
    logic [1:0] exp_en[4];
    logic [7:0] exp_rsp[4];
    cmds = '{8'h80, 8'h81, 8'hC0, 8'h85};
    exp_en = '{2'b01, 2'b11, 2'b10, 2'b10};
    exp_rsp = '{8'hA5, 8'hA5, 8'hA5, 8'hE1};
    for (int i = 0; i < 4; i++) begin
      put(cmds[i]);
      quiet(1);
      checks++;
      if (den !== exp_en[i] || tx_av !== 1'b1 || tx !== exp_rsp[i] || busy !== 1'b0) begin
        errors++;
        $display("FAIL en_cmd%0d got en=%b txv=%b tx=%h busy=%b want en=%b txv=1 tx=%h busy=0",
                 i, den, tx_av, tx, busy, exp_en[i], exp_rsp[i]);
      end
      quiet(1);
    end
  endtask

  task automatic test_bad_unit;
    wq.delete(); tq.delete();
    put(8'h05); put(8'h00); put(8'h00); put(8'h01);
    put_word(32'h55667788);
    quiet(4);
    checks++;
    if (wq.size() != 0 || den !== 2'b10) begin
      errors++;
      $display("FAIL bad_nowrite got writes=%0d en=%b want 0 10", wq.size(), den);
    end
    checks++;
    if (tq.size() != 1 || tq[0] !== 8'hE1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_resp got n=%0d first=%h busy=%b want 1 e1 0", tq.size(), (tq.size() > 0) ? tq[0] : 8'hxx, busy);
    end
  endtask

  task automatic test_timeout;
    int n;
    logic seen;
    wq.delete(); tq.delete();
    put(8'h00); put(8'h00); put(8'h10); put(8'h02);
    put_word(32'h01020304);
    put(8'hAA); put(8'hBB);
    n = 0; seen = 1'b0;
    while (!seen && n < TO + 20) begin
      quiet(1);
      n++;
      if (tx_av) seen = 1'b1;
    end
    checks++;
    if (!seen || n < TO || n > TO + 2) begin
      errors++;
      $display("FAIL to_latency got seen=%b cycles=%0d want 1 %0d..%0d", seen, n, TO, TO + 2);
    end
    checks++;
    if (tx !== 8'hE2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_resp got tx=%h busy=%b want e2 0", tx, busy);
    end
    quiet(2);
    checks++;
    if (wq.size() != 1 || (wq.size() > 0 && wq[0] !== {2'b01, 1'b0, 10'h010, 32'h01020304})) begin
      errors++;
      $display("FAIL to_partial got writes=%0d want 1 at 010", wq.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [44:0] exp_w[3];
    exp_w[0] = {2'b01, 1'b0, 10'h020, 32'hCAFEBABE};
    exp_w[1] = {2'b10, 1'b1, 10'h005, 32'h12345678};
    exp_w[2] = {2'b01, 1'b0, 10'h030, 32'h0BADF00D};
    wq.delete(); tq.delete();
    put(8'h00); put(8'h00); put(8'h20); put(8'h01);
    put_word(32'hCAFEBABE);
    put(8'h41); put(8'h00); put(8'h05); put(8'h01);
    put_word(32'h12345678);
    put(8'h00); put(8'h00); put(8'h30); put(8'h02);
    put_word(32'h0BADF00D);
    put(8'h77); put(8'h66);
    @(negedge clk);
    avail = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({tx_av, tx, we, sel, addr, data, den, busy} !== 57'd0) begin
      errors++;
      $display("FAIL b2b_reset_outputs got %h want 0", {tx_av, tx, we, sel, addr, data, den, busy});
    end
    quiet(TO + 5);
    checks++;
    if (wq.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", wq.size());
    end
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL b2b_write%0d got %h want %h", i, wq[i], exp_w[i]);
      end
    end
    checks++;
    if (tq.size() != 2 || tq[0] !== 8'hA5 || tq[1] !== 8'hA5) begin
      errors++;
      $display("FAIL b2b_resp got n=%0d want two a5", tq.size());
    end
    put(8'h81);
    quiet(1);
    checks++;
    if (den !== 2'b10 || tx !== 8'hA5 || tx_av !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after_reset got en=%b txv=%b tx=%h want 10 1 a5", den, tx_av, tx);
    end
  endtask

  initial begin
    rst = 1'b1; avail = 1'b0; rx = 8'h00;
    test_reset();
    test_write_instr();
    test_write_data_wrap();
    test_enable();
    test_bad_unit();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
